rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 The block SHALL have parameter IALU_WORD_WIDTH, default 16, the register data width.
REQ-002 The block SHALL have parameter REG_IDX_WIDTH, default 4, the register index width; NREGS = 2**REG_IDX_WIDTH.
REQ-003 The block SHALL have port clock, input, 1 bit, the system clock.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous, active-high reset.
REQ-005 The block SHALL have port in_alu_vld, input, 1 bit, ALU writeback result valid.
REQ-006 The block SHALL have port in_alu_res, input, IALU_WORD_WIDTH, ALU result data.
REQ-007 The block SHALL have port in_alu_idx, input, REG_IDX_WIDTH, ALU destination register.
REQ-008 The block SHALL have port out_alu_stall, output, 1 bit, ALU side hold buffer full; upstream must freeze.
REQ-009 The block SHALL have port in_ld_vld, input, 1 bit, load-return data valid.
REQ-010 The block SHALL have port in_ld_data, input, IALU_WORD_WIDTH, load-return data.
REQ-011 The block SHALL have port in_ld_idx, input, REG_IDX_WIDTH, load destination register.
REQ-012 The block SHALL have port out_ld_rdy, output, 1 bit, load-return accepted this cycle (combinational).
REQ-013 The block SHALL have ports out_rf_we (1 bit), out_rf_idx (REG_IDX_WIDTH) and out_rf_data (IALU_WORD_WIDTH), all outputs and all registered, forming the register-file write port.
REQ-014 The block SHALL have port out_pend_mask, output, NREGS bits; bit i set while the hold buffer holds a write to register i.

Function
REQ-015 ALU candidate SHALL be the hold buffer when hold_full=1, else in_alu_vld/in_alu_res/in_alu_idx; ALU inputs SHALL be ignored while out_alu_stall=1.
REQ-016 out_alu_stall SHALL equal hold_full (registered, no combinational path from inputs).
REQ-017 Only one requester pending: it SHALL be granted in the same cycle.
REQ-018 Both pending with differing indices: grant SHALL follow the 1-bit round-robin pointer rr (0 = ALU preferred, 1 = load preferred), and rr SHALL then point at the loser.
REQ-019 Both pending with equal indices: load SHALL be granted first and ALU second (ALU value is final), regardless of rr; rr SHALL be left unchanged.
REQ-020 Single-requester grants SHALL leave rr unchanged.
REQ-021 Granted write SHALL appear on out_rf_we/out_rf_idx/out_rf_data on the next rising edge (latency 1); with no grant, out_rf_we SHALL be 0 next cycle and idx/data SHALL hold their previous values.
REQ-022 out_ld_rdy SHALL be 1 exactly in cycles where the load request is granted; a non-granted load SHALL be held stable by the source.
REQ-023 An ALU input that loses arbitration SHALL be captured into the hold buffer (hold_full=1 next cycle); a losing hold buffer SHALL keep its contents.
REQ-024 The hold buffer SHALL clear (hold_full=0) on the edge following its grant; a new ALU input SHALL be accepted no earlier than the following cycle.
REQ-025 The round-robin rule SHALL guarantee no requester waits more than one grant while the other is continuously pending.
REQ-026 out_pend_mask SHALL be all zeros when hold_full=0, else one-hot at the held index.

Reset
REQ-027 While reset=1: out_rf_we=0, out_rf_idx=0, out_rf_data=0, hold_full=0, rr=0, hold contents=0, out_alu_stall=0, out_pend_mask=0; out_ld_rdy SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL discard any held ALU result without writing it.
REQ-029 After reset release, the first cycle with both requesters pending SHALL grant ALU.

Verification
REQ-030 ALU only: in_alu_vld=1, idx=3, res=0x1234 -> next cycle out_rf_we=1, idx=3, data=0x1234; out_alu_stall stays 0.
REQ-031 Collision after reset: ALU idx=2 res=0xAAAA, load idx=5 data=0x5555 same cycle -> cycle+1 writes r2=0xAAAA, out_ld_rdy=0; cycle+1 load granted (rr=1), cycle+2 writes r5=0x5555.
REQ-032 Load wins with ALU in input: rr=1, ALU idx=7 res=0x0F0F, load idx=1 -> load written first, hold_full=1, out_alu_stall=1, out_pend_mask=0x0080; next cycle r7=0x0F0F written, stall drops.
REQ-033 Same-index: ALU idx=4 res=0x0001, load idx=4 data=0x0002 -> writes r4=0x0002 then r4=0x0001; rr unchanged.
REQ-034 Continuous load with ALU stream: in_ld_vld=1 for 6 cycles, in_alu_vld=1 -> out_rf_we=1 every cycle, grants alternate, no requester waits more than 1 cycle.
REQ-035 Reset while hold_full=1 (idx=9) -> all outputs 0 immediately, r9 never written, out_pend_mask=0.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: merges ALU writeback and load-return traffic into one RF write port.
// A one-entry hold buffer parks an ALU result that lost arbitration; a 1-bit round-robin pointer keeps both sides fair.
module rf_write_arbiter #(
    parameter int IALU_WORD_WIDTH = 16,
    parameter int REG_IDX_WIDTH   = 4,
    localparam int NREGS          = 2**REG_IDX_WIDTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_alu_vld,
    input  logic [IALU_WORD_WIDTH-1:0] in_alu_res,
    input  logic [REG_IDX_WIDTH-1:0]   in_alu_idx,
    output logic                       out_alu_stall,
    input  logic                       in_ld_vld,
    input  logic [IALU_WORD_WIDTH-1:0] in_ld_data,
    input  logic [REG_IDX_WIDTH-1:0]   in_ld_idx,
    output logic                       out_ld_rdy,
    output logic                       out_rf_we,
    output logic [REG_IDX_WIDTH-1:0]   out_rf_idx,
    output logic [IALU_WORD_WIDTH-1:0] out_rf_data,
    output logic [NREGS-1:0]           out_pend_mask
);

    logic                       hold_full;
    logic [REG_IDX_WIDTH-1:0]   hold_idx;
    logic [IALU_WORD_WIDTH-1:0] hold_data;
    logic                       rr;

    logic                       alu_req;
    logic [REG_IDX_WIDTH-1:0]   alu_idx;
    logic [IALU_WORD_WIDTH-1:0] alu_data;
    logic                       both_req;
    logic                       same_idx;
    logic                       grant_alu;
    logic                       grant_ld;

    // While the hold buffer is occupied it is the ALU candidate and live ALU inputs are ignored.
    always_comb begin
        alu_req   = hold_full | in_alu_vld;
        alu_idx   = hold_full ? hold_idx  : in_alu_idx;
        alu_data  = hold_full ? hold_data : in_alu_res;
        both_req  = alu_req & in_ld_vld;
        same_idx  = both_req & (alu_idx == in_ld_idx);
        grant_alu = 1'b0;
        grant_ld  = 1'b0;
        if (both_req) begin
            // Same destination: load goes first so the ALU value lands last.
            if (same_idx || rr) grant_ld  = 1'b1;
            else                grant_alu = 1'b1;
        end else begin
            grant_alu = alu_req;
            grant_ld  = in_ld_vld;
        end
    end

    assign out_ld_rdy    = grant_ld & ~reset;
    assign out_alu_stall = hold_full;
    assign out_pend_mask = hold_full ? (NREGS'(1) << hold_idx) : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_rf_we   <= 1'b0;
            out_rf_idx  <= '0;
            out_rf_data <= '0;
            hold_full   <= 1'b0;
            hold_idx    <= '0;
            hold_data   <= '0;
            rr          <= 1'b0;
        end else begin
            out_rf_we <= grant_alu | grant_ld;
            if (grant_alu) begin
                out_rf_idx  <= alu_idx;
                out_rf_data <= alu_data;
            end else if (grant_ld) begin
                out_rf_idx  <= in_ld_idx;
                out_rf_data <= in_ld_data;
            end

            // Pointer moves only on a real contention and then names the loser.
            if (both_req && !same_idx)
                rr <= grant_alu;

            if (hold_full) begin
                if (grant_alu)
                    hold_full <= 1'b0;
            end else if (in_alu_vld && !grant_alu) begin
                hold_full <= 1'b1;
                hold_idx  <= in_alu_idx;
                hold_data <= in_alu_res;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed vector table, async-reset sequence,
// and randomized traffic against a cycle-level reference model of the arbitration rules.
module tb_rf_write_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_alu_vld = 1'b0;
    logic [15:0] in_alu_res = '0;
    logic [3:0]  in_alu_idx = '0;
    logic        out_alu_stall;
    logic        in_ld_vld = 1'b0;
    logic [15:0] in_ld_data = '0;
    logic [3:0]  in_ld_idx = '0;
    logic        out_ld_rdy;
    logic        out_rf_we;
    logic [3:0]  out_rf_idx;
    logic [15:0] out_rf_data;
    logic [15:0] out_pend_mask;

    int npass = 0;
    int ntot  = 0;

    rf_write_arbiter #(.IALU_WORD_WIDTH(16), .REG_IDX_WIDTH(4)) dut (
        .clock(clock), .reset(reset),
        .in_alu_vld(in_alu_vld), .in_alu_res(in_alu_res), .in_alu_idx(in_alu_idx),
        .out_alu_stall(out_alu_stall),
        .in_ld_vld(in_ld_vld), .in_ld_data(in_ld_data), .in_ld_idx(in_ld_idx),
        .out_ld_rdy(out_ld_rdy),
        .out_rf_we(out_rf_we), .out_rf_idx(out_rf_idx), .out_rf_data(out_rf_data),
        .out_pend_mask(out_pend_mask)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic av, input logic [3:0] ai, input logic [15:0] ad,
                         input logic lv, input logic [3:0] li, input logic [15:0] ld);
        in_alu_vld = av; in_alu_idx = ai; in_alu_res = ad;
        in_ld_vld  = lv; in_ld_idx  = li; in_ld_data = ld;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"},    32'(out_rf_we), 32'd0);
        chk({tag, "_idx"},   32'(out_rf_idx), 32'd0);
        chk({tag, "_data"},  32'(out_rf_data), 32'd0);
        chk({tag, "_stall"}, 32'(out_alu_stall), 32'd0);
        chk({tag, "_pend"},  32'(out_pend_mask), 32'd0);
        chk({tag, "_rdy"},   32'(out_ld_rdy), 32'd0);
    endtask

    // Directed vectors: inputs for one cycle, expected pre-edge status, expected post-edge write port.
    typedef struct {
        logic        av; logic [3:0] ai; logic [15:0] ad;
        logic        lv; logic [3:0] li; logic [15:0] ld;
        logic        e_rdy; logic e_stall; logic [15:0] e_pend;
        logic        e_we; logic [3:0] e_idx; logic [15:0] e_data;
    } vec_t;
    vec_t vecs[11];

    // Reference model: pending ALU entry, fairness pointer, expected write port.
    logic        m_hold_v, m_rr, m_we, m_ld_gnt;
    logic [3:0]  m_hold_i, m_idx;
    logic [15:0] m_hold_d, m_data;
    int          ld_wait;

    task automatic model_reset();
        m_hold_v = 0; m_hold_i = '0; m_hold_d = '0; m_rr = 0;
        m_we = 0; m_idx = '0; m_data = '0; m_ld_gnt = 0; ld_wait = 0;
    endtask

    task automatic mcycle(input logic av, input logic [3:0] ai, input logic [15:0] ad,
                          input logic lv, input logic [3:0] li, input logic [15:0] ld);
        logic        a_req;
        logic [3:0]  a_i;
        logic [15:0] a_d;
        int          winner; // 0 none, 1 alu, 2 load
        drive(av, ai, ad, lv, li, ld);
        a_req = m_hold_v || av;
        a_i   = m_hold_v ? m_hold_i : ai;
        a_d   = m_hold_v ? m_hold_d : ad;
        if (a_req && lv) begin
            if (a_i == li) winner = 2;
            else begin
                winner = m_rr ? 2 : 1;
                m_rr   = (winner == 1);
            end
        end else if (a_req) winner = 1;
        else if (lv)        winner = 2;
        else                winner = 0;
        @(negedge clock);
        chk("m_ld_rdy", 32'(out_ld_rdy), 32'(winner == 2));
        chk("m_stall",  32'(out_alu_stall), 32'(m_hold_v));
        chk("m_pend",   32'(out_pend_mask), m_hold_v ? 32'(16'd1 << m_hold_i) : 32'd0);
        if (lv) begin
            ld_wait = (winner == 2) ? 0 : ld_wait + 1;
            chk("m_ld_wait_le1", 32'(ld_wait <= 1), 32'd1);
        end
        m_we = (winner != 0);
        if (winner == 1) begin m_idx = a_i; m_data = a_d; end
        if (winner == 2) begin m_idx = li;  m_data = ld;  end
        if (m_hold_v) m_hold_v = (winner != 1);
        else if (av && winner != 1) begin
            m_hold_v = 1; m_hold_i = ai; m_hold_d = ad;
        end
        m_ld_gnt = (winner == 2);
        @(posedge clock); #1;
        chk("m_we", 32'(out_rf_we), 32'(m_we));
        if (m_we) begin
            chk("m_idx",  32'(out_rf_idx), 32'(m_idx));
            chk("m_data", 32'(out_rf_data), 32'(m_data));
        end
    endtask

    initial begin
        logic        p_lv;
        logic [3:0]  p_li;
        logic [15:0] p_ld;

        vecs[0]  = '{1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd3, 16'h1234};
        vecs[1]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd3, 16'h1234};
        vecs[2]  = '{1'b1, 4'd2, 16'hAAAA, 1'b1, 4'd5, 16'h5555, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd2, 16'hAAAA};
        vecs[3]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 4'd5, 16'h5555};
        vecs[4]  = '{1'b1, 4'd7, 16'h0F0F, 1'b1, 4'd1, 16'h1111, 1'b1, 1'b0, 16'h0000, 1'b1, 4'd1, 16'h1111};
        vecs[5]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 16'h0080, 1'b1, 4'd7, 16'h0F0F};
        vecs[6]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd7, 16'h0F0F};
        vecs[7]  = '{1'b1, 4'd4, 16'h0001, 1'b1, 4'd4, 16'h0002, 1'b1, 1'b0, 16'h0000, 1'b1, 4'd4, 16'h0002};
        vecs[8]  = '{1'b1, 4'd9, 16'hDEAD, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 16'h0010, 1'b1, 4'd4, 16'h0001};
        vecs[9]  = '{1'b1, 4'd6, 16'h0606, 1'b1, 4'd8, 16'h0808, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd6, 16'h0606};
        vecs[10] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd8, 16'h0808, 1'b1, 1'b0, 16'h0000, 1'b1, 4'd8, 16'h0808};

        // Power-on reset with a load request present: ld_rdy must still be low.
        #1 reset = 1'b1;
        drive(1'b1, 4'd3, 16'hFFFF, 1'b1, 4'd2, 16'hFFFF);
        #1 chk_all_zero("in_reset");
        @(posedge clock); @(posedge clock); #1;
        drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        reset = 1'b0;
        #1 chk_all_zero("after_reset");

        foreach (vecs[k]) begin
            drive(vecs[k].av, vecs[k].ai, vecs[k].ad, vecs[k].lv, vecs[k].li, vecs[k].ld);
            @(negedge clock);
            chk($sformatf("v%0d_rdy", k),   32'(out_ld_rdy), 32'(vecs[k].e_rdy));
            chk($sformatf("v%0d_stall", k), 32'(out_alu_stall), 32'(vecs[k].e_stall));
            chk($sformatf("v%0d_pend", k),  32'(out_pend_mask), 32'(vecs[k].e_pend));
            @(posedge clock); #1;
            chk($sformatf("v%0d_we", k),   32'(out_rf_we), 32'(vecs[k].e_we));
            chk($sformatf("v%0d_idx", k),  32'(out_rf_idx), 32'(vecs[k].e_idx));
            chk($sformatf("v%0d_data", k), 32'(out_rf_data), 32'(vecs[k].e_data));
        end

        // Pointer favours load here: ALU idx 9 gets parked, then reset discards it.
        drive(1'b1, 4'd9, 16'h9999, 1'b1, 4'd0, 16'h0A0A);
        @(negedge clock);
        chk("r35_rdy", 32'(out_ld_rdy), 32'd1);
        @(posedge clock); #1;
        chk("r35_we",    32'(out_rf_we), 32'd1);
        chk("r35_data",  32'(out_rf_data), 32'h0A0A);
        chk("r35_stall", 32'(out_alu_stall), 32'd1);
        chk("r35_pend",  32'(out_pend_mask), 32'h0200);
        drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd2, 16'h2222);
        #2 reset = 1'b1;
        #1 chk_all_zero("mid_reset");
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
        mcycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        mcycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        chk("r35_no_r9", 32'(out_rf_we), 32'd0);
        mcycle(1'b1, 4'd5, 16'h5A5A, 1'b1, 4'd6, 16'h6B6B);
        chk("r29_alu_first", 32'(out_rf_idx), 32'd5);

        // Saturated traffic on both sides: a write every cycle, alternating sources.
        model_reset();
        reset = 1'b1; #1; @(posedge clock); #1; reset = 1'b0;
        p_lv = 1'b1; p_li = 4'd8; p_ld = 16'h8000;
        for (int k = 0; k < 6; k++) begin
            mcycle(1'b1, 4'(k % 2 + 1), 16'(16'hA000 + k), p_lv, p_li, p_ld);
            chk("r34_we", 32'(out_rf_we), 32'd1);
            if (m_ld_gnt) begin p_li = 4'(8 + k); p_ld = 16'(16'h8001 + k); end
        end

        // Randomized traffic; small index range makes same-destination collisions frequent.
        p_lv = 1'b0; p_li = '0; p_ld = '0;
        for (int k = 0; k < 400; k++) begin
            if (!p_lv && ($urandom % 3 != 0)) begin
                p_lv = 1'b1;
                p_li = 4'($urandom_range(0, 3));
                p_ld = 16'($urandom);
            end
            mcycle(1'($urandom % 2), 4'($urandom_range(0, 3)), 16'($urandom), p_lv, p_li, p_ld);
            if (m_ld_gnt) p_lv = 1'b0;
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
